// File: rtl/map_table_ss_pkg.sv
// Shared types and default sizing for the superscalar rename map table.
// Consumers at default widths use map_entry_t / map_src_packet_t directly.
package map_table_ss_pkg;

    localparam int MT_NUM_ARCH   = 32;
    localparam int MT_TAG_W      = 5;
    localparam int MT_DISPATCH_W = 2;
    localparam int MT_CDB_W      = 2;
    localparam int MT_RETIRE_W   = 2;
    localparam int MT_NUM_CKPT   = 4;

    typedef struct packed {
        logic                busy;
        logic                ready;
        logic [MT_TAG_W-1:0] tag;
    } map_entry_t;

    typedef struct packed {
        logic                busy;
        logic                ready;
        logic [MT_TAG_W-1:0] tag;
    } map_src_packet_t;

endpackage

// File: rtl/map_ckpt_store.sv
// Circular queue of map-table snapshots; stored copies track CDB completions
// and retirements so a restored map is current.
module map_ckpt_store
    import map_table_ss_pkg::*;
#(
    parameter int NUM_ARCH = MT_NUM_ARCH,
    parameter int TAG_W    = MT_TAG_W,
    parameter int CDB_W    = MT_CDB_W,
    parameter int RETIRE_W = MT_RETIRE_W,
    parameter int NUM_CKPT = MT_NUM_CKPT,
    localparam int AW      = $clog2(NUM_ARCH),
    localparam int CW      = $clog2(NUM_CKPT),
    localparam int EW      = 2 + TAG_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CDB_W-1:0]          cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]    cdb_tag,
    input  logic [RETIRE_W-1:0]       ret_valid,
    input  logic [RETIRE_W*AW-1:0]    ret_idx,
    input  logic [RETIRE_W*TAG_W-1:0] ret_tag,
    input  logic                      ckpt_req,
    input  logic [NUM_ARCH*EW-1:0]    snap_in,
    input  logic                      ckpt_release,
    input  logic                      recover_valid,
    input  logic [CW-1:0]             recover_id,
    output logic [CW-1:0]             ckpt_id,
    output logic                      ckpt_full,
    output logic [NUM_ARCH*EW-1:0]    restore_out
);

    typedef struct packed {
        logic             busy;
        logic             ready;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t        ckpt_q   [NUM_CKPT][NUM_ARCH];
    entry_t        ckpt_upd [NUM_CKPT][NUM_ARCH];
    logic [CW-1:0] head, tail, head_n;
    logic [CW:0]   count;
    logic          take;

    assign ckpt_full = (count == (CW+1)'(NUM_CKPT));
    assign ckpt_id   = tail;
    assign take      = ckpt_req && !ckpt_full && !recover_valid;
    assign head_n    = (ckpt_release && count != '0) ? head + 1'b1 : head;

    always_comb begin
        // NOTE: every always_comb target gets a full default first so no latch is inferred.
        restore_out = '0;
        for (int c = 0; c < NUM_CKPT; c++) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                entry_t e;
                e = ckpt_q[c][i];
                for (int b = 0; b < CDB_W; b++)
                    if (e.busy && cdb_valid[b] && cdb_tag[b*TAG_W +: TAG_W] == e.tag)
                        e.ready = 1'b1;
                for (int r = 0; r < RETIRE_W; r++)
                    if (e.busy && ret_valid[r] && ret_idx[r*AW +: AW] == AW'(i) &&
                        ret_tag[r*TAG_W +: TAG_W] == e.tag)
                        e = '0;
                ckpt_upd[c][i] = e;
            end
        end
        for (int i = 0; i < NUM_ARCH; i++)
            restore_out[i*EW +: EW] = ckpt_upd[recover_id][i];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: snapshots are cleared on reset so no stale mapping survives into a restore.
            for (int c = 0; c < NUM_CKPT; c++)
                for (int i = 0; i < NUM_ARCH; i++)
                    ckpt_q[c][i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; the later tail write wins.
            for (int c = 0; c < NUM_CKPT; c++)
                for (int i = 0; i < NUM_ARCH; i++)
                    ckpt_q[c][i] <= ckpt_upd[c][i];
            if (take)
                for (int i = 0; i < NUM_ARCH; i++)
                    ckpt_q[tail][i] <= snap_in[i*EW +: EW];

            head <= head_n;
            if (recover_valid) begin
                // Release is folded into head_n before the rewind.
                tail  <= recover_id;
                count <= {1'b0, CW'(recover_id - head_n)};
            end else begin
                tail  <= take ? tail + 1'b1 : tail;
                count <= count - (CW+1)'(head_n != head) + (CW+1)'(take);
            end
        end
    end

endmodule

// File: rtl/map_table_ss.sv
// Superscalar register rename map: per-arch-reg {busy, ready, tag} with
// intra-group and CDB bypass on lookup, plus branch checkpoint recovery.
module map_table_ss
    import map_table_ss_pkg::*;
#(
    parameter int NUM_ARCH   = MT_NUM_ARCH,
    parameter int TAG_W      = MT_TAG_W,
    parameter int DISPATCH_W = MT_DISPATCH_W,
    parameter int CDB_W      = MT_CDB_W,
    parameter int RETIRE_W   = MT_RETIRE_W,
    parameter int NUM_CKPT   = MT_NUM_CKPT,
    localparam int AW        = $clog2(NUM_ARCH),
    localparam int CW        = $clog2(NUM_CKPT),
    localparam int SW        = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1,
    localparam int EW        = 2 + TAG_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DISPATCH_W-1:0]       disp_valid,
    input  logic [DISPATCH_W-1:0]       disp_has_dest,
    input  logic [DISPATCH_W*AW-1:0]    disp_dest_idx,
    input  logic [DISPATCH_W*TAG_W-1:0] disp_tag,
    input  logic [DISPATCH_W-1:0]       disp_rs1_valid,
    input  logic [DISPATCH_W-1:0]       disp_rs2_valid,
    input  logic [DISPATCH_W*AW-1:0]    disp_rs1_idx,
    input  logic [DISPATCH_W*AW-1:0]    disp_rs2_idx,
    output logic [DISPATCH_W-1:0]       src1_busy,
    output logic [DISPATCH_W-1:0]       src2_busy,
    output logic [DISPATCH_W-1:0]       src1_ready,
    output logic [DISPATCH_W-1:0]       src2_ready,
    output logic [DISPATCH_W*TAG_W-1:0] src1_tag,
    output logic [DISPATCH_W*TAG_W-1:0] src2_tag,
    input  logic [CDB_W-1:0]            cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]      cdb_tag,
    input  logic [RETIRE_W-1:0]         ret_valid,
    input  logic [RETIRE_W*AW-1:0]      ret_idx,
    input  logic [RETIRE_W*TAG_W-1:0]   ret_tag,
    input  logic                        ckpt_req,
    input  logic [SW-1:0]               ckpt_slot,
    output logic [CW-1:0]               ckpt_id,
    output logic                        ckpt_full,
    input  logic                        ckpt_release,
    input  logic                        recover_valid,
    input  logic [CW-1:0]               recover_id,
    output logic [NUM_ARCH*EW-1:0]      map_dbg
);

    typedef struct packed {
        logic             busy;
        logic             ready;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t                   map_q [NUM_ARCH];
    entry_t                   map_d [NUM_ARCH];
    entry_t                   snap  [NUM_ARCH];
    entry_t                   restore_map [NUM_ARCH];
    logic [NUM_ARCH*EW-1:0]   snap_flat, restore_flat;

    function automatic logic tag_done(input logic [CDB_W-1:0] v,
                                      input logic [CDB_W*TAG_W-1:0] t,
                                      input logic [TAG_W-1:0] tag);
        tag_done = 1'b0;
        for (int b = 0; b < CDB_W; b++)
            if (v[b] && t[b*TAG_W +: TAG_W] == tag) tag_done = 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_ARCH; i++) begin
            entry_t e;
            e = map_q[i];
            if (e.busy && tag_done(cdb_valid, cdb_tag, e.tag)) e.ready = 1'b1;
            for (int r = 0; r < RETIRE_W; r++)
                if (e.busy && ret_valid[r] && ret_idx[r*AW +: AW] == AW'(i) &&
                    ret_tag[r*TAG_W +: TAG_W] == e.tag)
                    e = '0;
            map_d[i] = e;
        end
        snap = map_d;
        // Slots after the branch are kept out of the snapshot.
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (disp_valid[k] && disp_has_dest[k] && disp_dest_idx[k*AW +: AW] != '0) begin
                map_d[disp_dest_idx[k*AW +: AW]] = '{busy: 1'b1, ready: 1'b0,
                                                     tag: disp_tag[k*TAG_W +: TAG_W]};
                if (SW'(k) <= ckpt_slot)
                    snap[disp_dest_idx[k*AW +: AW]] = '{busy: 1'b1, ready: 1'b0,
                                                        tag: disp_tag[k*TAG_W +: TAG_W]};
            end
        end
        for (int i = 0; i < NUM_ARCH; i++) begin
            snap_flat[i*EW +: EW] = snap[i];
            restore_map[i]        = restore_flat[i*EW +: EW];
            map_dbg[i*EW +: EW]   = map_q[i];
        end
    end

    always_comb begin
        src1_busy = '0; src1_ready = '0; src1_tag = '0;
        src2_busy = '0; src2_ready = '0; src2_tag = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            for (int s = 0; s < 2; s++) begin
                logic          sv;
                logic [AW-1:0] sidx;
                entry_t        r;
                sv   = (s == 0) ? disp_rs1_valid[k] : disp_rs2_valid[k];
                sidx = (s == 0) ? disp_rs1_idx[k*AW +: AW] : disp_rs2_idx[k*AW +: AW];
                r    = '0;
                if (sv && sidx != '0) begin
                    r = map_q[sidx];
                    if (r.busy && tag_done(cdb_valid, cdb_tag, r.tag)) r.ready = 1'b1;
                    for (int j = 0; j < k; j++)
                        if (disp_valid[j] && disp_has_dest[j] && disp_dest_idx[j*AW +: AW] == sidx)
                            r = '{busy: 1'b1, ready: 1'b0, tag: disp_tag[j*TAG_W +: TAG_W]};
                end
                if (s == 0) begin
                    src1_busy[k] = r.busy; src1_ready[k] = r.ready;
                    src1_tag[k*TAG_W +: TAG_W] = r.tag;
                end else begin
                    src2_busy[k] = r.busy; src2_ready[k] = r.ready;
                    src2_tag[k*TAG_W +: TAG_W] = r.tag;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= '0;
        end else if (recover_valid) begin
            map_q <= restore_map;
        end else begin
            map_q <= map_d;
        end
    end

    map_ckpt_store #(
        .NUM_ARCH (NUM_ARCH),
        .TAG_W    (TAG_W),
        .CDB_W    (CDB_W),
        .RETIRE_W (RETIRE_W),
        .NUM_CKPT (NUM_CKPT)
    ) u_ckpt (
        .clock         (clock),
        .reset         (reset),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .ret_valid     (ret_valid),
        .ret_idx       (ret_idx),
        .ret_tag       (ret_tag),
        .ckpt_req      (ckpt_req),
        .snap_in       (snap_flat),
        .ckpt_release  (ckpt_release),
        .recover_valid (recover_valid),
        .recover_id    (recover_id),
        .ckpt_id       (ckpt_id),
        .ckpt_full     (ckpt_full),
        .restore_out   (restore_flat)
    );

endmodule

// File: tb/tb_map_table_ss.sv
// Directed bench for map_table_ss: lookup bypasses, retire filtering,
// checkpoint queue wrap and recovery, with hand-computed expectations.
module tb_map_table_ss;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  disp_valid, disp_has_dest, disp_rs1_valid, disp_rs2_valid;
    logic [9:0]  disp_dest_idx, disp_tag, disp_rs1_idx, disp_rs2_idx;
    logic [1:0]  src1_busy, src2_busy, src1_ready, src2_ready;
    logic [9:0]  src1_tag, src2_tag;
    logic [1:0]  cdb_valid, ret_valid;
    logic [9:0]  cdb_tag, ret_idx, ret_tag;
    logic        ckpt_req, ckpt_full, ckpt_release, recover_valid;
    logic [0:0]  ckpt_slot;
    logic [1:0]  ckpt_id, recover_id;
    logic [223:0] map_dbg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    map_table_ss dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_has_dest(disp_has_dest),
        .disp_dest_idx(disp_dest_idx), .disp_tag(disp_tag),
        .disp_rs1_valid(disp_rs1_valid), .disp_rs2_valid(disp_rs2_valid),
        .disp_rs1_idx(disp_rs1_idx), .disp_rs2_idx(disp_rs2_idx),
        .src1_busy(src1_busy), .src2_busy(src2_busy),
        .src1_ready(src1_ready), .src2_ready(src2_ready),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .ret_valid(ret_valid), .ret_idx(ret_idx), .ret_tag(ret_tag),
        .ckpt_req(ckpt_req), .ckpt_slot(ckpt_slot), .ckpt_id(ckpt_id),
        .ckpt_full(ckpt_full), .ckpt_release(ckpt_release),
        .recover_valid(recover_valid), .recover_id(recover_id),
        .map_dbg(map_dbg)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] ent(input logic b, input logic r, input logic [4:0] t);
        return {b, r, t};
    endfunction

    function automatic logic [6:0] dbg(input int i);
        return map_dbg[i*7 +: 7];
    endfunction

    task automatic clear_inputs();
        disp_valid = '0; disp_has_dest = '0; disp_dest_idx = '0; disp_tag = '0;
        disp_rs1_valid = '0; disp_rs2_valid = '0; disp_rs1_idx = '0; disp_rs2_idx = '0;
        cdb_valid = '0; cdb_tag = '0; ret_valid = '0; ret_idx = '0; ret_tag = '0;
        ckpt_req = 0; ckpt_slot = '0; ckpt_release = 0; recover_valid = 0; recover_id = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic set_disp(input int k, input logic [4:0] dest, input logic [4:0] tag);
        disp_valid[k] = 1'b1; disp_has_dest[k] = 1'b1;
        disp_dest_idx[k*5 +: 5] = dest; disp_tag[k*5 +: 5] = tag;
    endtask

    task automatic set_rs1(input int k, input logic [4:0] idx);
        disp_valid[k] = 1'b1; disp_rs1_valid[k] = 1'b1; disp_rs1_idx[k*5 +: 5] = idx;
    endtask

    task automatic set_rs2(input int k, input logic [4:0] idx);
        disp_valid[k] = 1'b1; disp_rs2_valid[k] = 1'b1; disp_rs2_idx[k*5 +: 5] = idx;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        check("reset_map_zero", {31'b0, map_dbg == '0}, 1);
        check("reset_full", ckpt_full, 0);
        check("reset_ckpt_id", ckpt_id, 0);
        check("reset_src_idle", {src1_busy, src1_ready, src2_busy, src2_ready}, 0);

        // Intra-group bypass: slot1 reads x5 written by slot0 in the same cycle.
        set_disp(0, 5, 3); set_rs1(1, 5);
        #1;
        check("bypass_busy", src1_busy[1], 1);
        check("bypass_ready", src1_ready[1], 0);
        check("bypass_tag", src1_tag[9:5], 3);
        step();
        check("x5_mapped", dbg(5), ent(1, 0, 3));

        // CDB bypass on lookup, then table gets ready bit.
        set_rs1(0, 5); cdb_valid[1] = 1'b1; cdb_tag[9:5] = 3;
        #1;
        check("cdb_byp_busy", src1_busy[0], 1);
        check("cdb_byp_ready", src1_ready[0], 1);
        check("cdb_byp_tag", src1_tag[4:0], 3);
        step();
        check("x5_ready", dbg(5), ent(1, 1, 3));

        // Re-rename x5; stale retire must not clear it.
        set_disp(0, 5, 7);
        step();
        ret_valid[0] = 1'b1; ret_idx[4:0] = 5; ret_tag[4:0] = 3;
        step();
        check("retire_stale", dbg(5), ent(1, 0, 7));
        ret_valid[1] = 1'b1; ret_idx[9:5] = 5; ret_tag[9:5] = 7;
        step();
        check("retire_match", dbg(5), 0);

        // Both slots write x2; slot1 source x2 sees slot0's tag.
        set_disp(0, 2, 4); set_disp(1, 2, 6); set_rs2(1, 2);
        #1;
        check("bypass_src2_tag", src2_tag[9:5], 4);
        step();
        check("x2_last_wins", dbg(2), ent(1, 0, 6));
        set_disp(0, 0, 8); set_rs1(1, 0);
        #1;
        check("x0_lookup", {src1_busy[1], src1_ready[1], 3'b0, src1_tag[9:5]}, 0);
        step();
        check("x0_never_written", dbg(0), 0);

        // Branch in slot0: checkpoint holds x1->2, live table x1->9.
        set_disp(0, 1, 2); set_disp(1, 1, 9); ckpt_req = 1; ckpt_slot = 0;
        #1;
        check("ckpt_id_first", ckpt_id, 0);
        step();
        check("x1_live", dbg(1), ent(1, 0, 9));
        cdb_valid[0] = 1'b1; cdb_tag[4:0] = 2;
        step();
        check("x1_live_unaffected", dbg(1), ent(1, 0, 9));
        recover_valid = 1; recover_id = 0; set_disp(0, 3, 10); ckpt_req = 1;
        step();
        check("recover_x1", dbg(1), ent(1, 1, 2));
        check("recover_x2", dbg(2), ent(1, 0, 6));
        check("recover_blocks_disp", dbg(3), 0);
        check("recover_full", ckpt_full, 0);
        check("recover_tail", ckpt_id, 0);

        // Fill the queue: count must have been restored to zero.
        for (int i = 0; i < 4; i++) begin
            ckpt_req = 1;
            #1;
            check($sformatf("fill_id%0d", i), ckpt_id, i);
            check($sformatf("fill_notfull%0d", i), ckpt_full, 0);
            step();
        end
        check("full_after_4", ckpt_full, 1);
        ckpt_req = 1;
        step();
        check("full_req_ignored", ckpt_full, 1);
        check("full_req_tail", ckpt_id, 0);
        ckpt_release = 1;
        step();
        check("release_full", ckpt_full, 0);
        check("release_next_id", ckpt_id, 0);
        ckpt_req = 1;
        step();
        check("refill_full", ckpt_full, 1);

        // Release (head 1->2) then rewind tail to 2: queue becomes empty.
        ckpt_release = 1; recover_valid = 1; recover_id = 2;
        step();
        check("rewind_full", ckpt_full, 0);
        check("rewind_tail", ckpt_id, 2);
        for (int i = 0; i < 4; i++) begin
            ckpt_req = 1;
            #1;
            check($sformatf("wrap_id%0d", i), ckpt_id, (i + 2) % 4);
            step();
        end
        check("wrap_full", ckpt_full, 1);

        // Mid-stream reset clears everything.
        set_disp(0, 6, 11); reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("rst2_map_zero", {31'b0, map_dbg == '0}, 1);
        check("rst2_full", ckpt_full, 0);
        check("rst2_ckpt_id", ckpt_id, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/map_table_ss.md
Name: map_table_ss

Overview:
- Parametrised superscalar successor to the single-dispatch map table. Renames up to DISPATCH_W instructions per cycle by mapping each architectural register to a ROB tag plus a ready bit.
- Takes CDB_W completion broadcasts per cycle. Clears entries on retirement.
- Holds a circular queue of branch checkpoints for single-cycle misprediction recovery.
- Sits between the decode/dispatch stage and the RS/ROB; source lookups are combinational.

Parameters:
- NUM_ARCH, 32, architectural registers; index width AW = $clog2(NUM_ARCH).
- TAG_W, 5, ROB tag width.
- DISPATCH_W, 2, dispatch slots per cycle; slot 0 is oldest.
- CDB_W, 2, completion broadcasts per cycle.
- RETIRE_W, 2, retire slots per cycle.
- NUM_CKPT, 4, checkpoint depth (power of 2); id width CW = $clog2(NUM_CKPT).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- disp_valid  in  DISPATCH_W  slot carries a dispatched instruction
- disp_has_dest  in  DISPATCH_W  slot writes a destination
- disp_dest_idx  in  DISPATCH_W*AW  destination arch reg
- disp_tag  in  DISPATCH_W*TAG_W  ROB tag allocated to the slot
- disp_rs1_valid, disp_rs2_valid  in  DISPATCH_W  source used
- disp_rs1_idx, disp_rs2_idx  in  DISPATCH_W*AW  source arch regs
- src1_busy, src2_busy  out  DISPATCH_W  source is mapped to an in-flight tag
- src1_ready, src2_ready  out  DISPATCH_W  the mapped tag has completed (value is in the ROB)
- src1_tag, src2_tag  out  DISPATCH_W*TAG_W  mapped tag
- cdb_valid  in  CDB_W;  cdb_tag  in  CDB_W*TAG_W
- ret_valid  in  RETIRE_W;  ret_idx  in  RETIRE_W*AW;  ret_tag  in  RETIRE_W*TAG_W
- ckpt_req  in  1  take a checkpoint this cycle
- ckpt_slot  in  $clog2(DISPATCH_W)  slot holding the branch
- ckpt_id  out  CW  id assigned to this cycle's checkpoint (valid with ckpt_req)
- ckpt_full  out  1  all NUM_CKPT checkpoints in use
- ckpt_release  in  1  oldest branch resolved correct; pop the queue head
- recover_valid  in  1  mispredict
- recover_id  in  CW  checkpoint to restore
- map_dbg  out  NUM_ARCH*(2+TAG_W)  entry {busy, ready, tag} per register

Behaviour:
- Entry = {busy, ready, tag}.
- Reset (reset==0 at a clock edge): every entry is 0. Checkpoint head, tail and count are 0. ckpt_full=0, ckpt_id=0. Lookup outputs are 0 when no slot is valid.
- Lookup (combinational) for slot k, source s:
  - If the source is not valid or the index is 0 -> busy=0, ready=0, tag=0.
  - Else, if the youngest slot j<k with disp_valid&has_dest&dest==idx exists -> busy=1, ready=0, tag=disp_tag[j] (intra-group bypass).
  - Else -> the table entry, with ready forced to 1 if any cdb_valid&cdb_tag==entry.tag this cycle (CDB bypass).
- Table update at the edge, lowest to highest priority:
  1. CDB: set ready on every busy entry whose tag matches any valid cdb_tag.
  2. Retire: for each ret_valid slot, clear the entry at ret_idx only if it is busy and its tag == ret_tag. A mismatch means the register has been re-renamed; leave it.
  3. Dispatch: for slots 0..DISPATCH_W-1 in order, write {1,0,disp_tag} to dest_idx. A later slot overwrites an earlier one. Register 0 is never written.
- Checkpoints: circular queue with head (oldest), tail and count.
  - ckpt_req with count<NUM_CKPT: store the table as updated by CDB, retire and dispatch slots 0..ckpt_slot (slots after the branch excluded). ckpt_id = tail; tail++ ; count++.
  - ckpt_req while ckpt_full: ignored. Dispatch must stall; asserting it is an error for the bench to flag.
  - Stored checkpoints receive the same CDB-ready and retire-clear updates every cycle, so a restored map is never stale.
  - ckpt_release with count>0: head++, count--. Release on an empty queue: ignored.
- recover_valid: highest priority.
  - Table <= checkpoint[recover_id] with this cycle's CDB and retire updates applied.
  - Dispatch and ckpt_req in the same cycle are ignored.
  - tail = recover_id; recover_id and all younger checkpoints are freed; count recomputed as (recover_id - head) mod NUM_CKPT.
  - ckpt_release in the same cycle is applied before the tail rewind.
- Wrap-around: head and tail wrap modulo NUM_CKPT. ckpt_full = (count==NUM_CKPT).
- Reset during recovery or mid-stream: all state cleared, no partial restore.

Decomposition:
- Shared package:
  - MAP_ENTRY typedef {busy, ready, tag}.
  - Parameter defaults.
  - MAP_SRC_PACKET {busy, ready, tag} for RS/ROB consumers.
- Sub-module map_ckpt_store: checkpoint array plus head/tail/count. It applies the CDB and retire updates to its stored copies and outputs the selected snapshot.

Test Plan:
- Reset, then dispatch slot0 dest x5 tag 3 and slot1 rs1=x5 -> slot1 src1 busy=1, ready=0, tag=3. Next cycle, map_dbg[5]={1,0,3}.
- x5->tag 3, CDB tag 3 in the same cycle as a lookup of x5 -> ready=1 combinationally; the entry reads {1,1,3} next cycle.
- x5->tag 3, later x5->tag 7, then retire idx 5 tag 3 -> the entry stays {1,0,7}. Retire tag 7 -> the entry becomes {0,0,0}.
- Both slots write x2 (tags 4, 6) -> map_dbg[2] tag=6. Slot0 writes x0 -> map_dbg[0] stays 0.
- Branch in slot0 with ckpt_req: slot0 writes x1->tag 2, slot1 writes x1->tag 9, CDB tag 2 completes later, then recover to that id -> x1={1,1,2}, count=0.
- Take 4 checkpoints -> ckpt_full=1, ids 0..3. A fifth ckpt_req is ignored. Release the oldest -> ckpt_full=0, and the next ckpt_id=0 (wrap).
